// File: rtl/dump_ctrl.sv
// Trace dump controller: streams one channel of a captured 512-entry trace to a UART,
// oldest sample first, one RAM read / transmit handshake per byte.
module dump_ctrl #(
  parameter int unsigned DEPTH_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dump_start,
  input  logic [1:0]         dump_chan,
  input  logic               capture_done,
  input  logic [DEPTH_W-1:0] trace_end,
  input  logic [23:0]        ram_rdata,
  output logic [DEPTH_W-1:0] ram_addr,
  output logic               ram_en,
  output logic [7:0]         tx_data,
  output logic               trmt,
  input  logic               tx_done,
  output logic               dumping,
  output logic               dump_done,
  output logic               clr_capture_done
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRead   = 3'd1,
    StLatch  = 3'd2,
    StSend   = 3'd3,
    StWaitTx = 3'd4,
    StFinish = 3'd5
  } state_e;

  state_e             state_q;
  logic [1:0]         chan_q;
  logic [DEPTH_W-1:0] cnt_q;

  // All outputs are registered and asserted on the transition into the state they belong to,
  // so each strobe is high exactly while the FSM sits in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      chan_q           <= 2'd0;
      cnt_q            <= '0;
      ram_addr         <= '0;
      ram_en           <= 1'b0;
      tx_data          <= 8'h00;
      trmt             <= 1'b0;
      dumping          <= 1'b0;
      dump_done        <= 1'b0;
      clr_capture_done <= 1'b0;
    end else begin
      ram_en           <= 1'b0;
      trmt             <= 1'b0;
      dump_done        <= 1'b0;
      clr_capture_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (dump_start && capture_done && (dump_chan != 2'd3)) begin
            chan_q   <= dump_chan;
            // Oldest sample sits just after the last written address.
            ram_addr <= trace_end + 1'b1;
            cnt_q    <= '0;
            ram_en   <= 1'b1;
            dumping  <= 1'b1;
            state_q  <= StRead;
          end
        end
        StRead: begin
          state_q <= StLatch;
        end
        StLatch: begin
          case (chan_q)
            2'd0:    tx_data <= ram_rdata[7:0];
            2'd1:    tx_data <= ram_rdata[15:8];
            default: tx_data <= ram_rdata[23:16];
          endcase
          trmt    <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          if (tx_done) begin
            if (cnt_q == {DEPTH_W{1'b1}}) begin
              dump_done        <= 1'b1;
              clr_capture_done <= 1'b1;
              state_q          <= StFinish;
            end else begin
              ram_addr <= ram_addr + 1'b1;
              cnt_q    <= cnt_q + 1'b1;
              ram_en   <= 1'b1;
              state_q  <= StRead;
            end
          end
        end
        StFinish: begin
          dumping <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          dumping <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
